adder_4bit: RTL and testbench

- Registered two-operand unsigned binary adder, default 4-bit datapath, for the 15-bit CPU arithmetic path.
- Sum is wrap-around, modulo 2^WIDTH. Carry-out and signed-overflow flags are provided.
- One register stage, so inputs present in cycle N produce the result after the clock edge ending cycle N.
- The datapath is built as an explicit ripple-carry chain of full-adder cells, one per bit, generated from WIDTH.

---
 rtl/adder_4bit.sv | 81 ++++++++
 tb/tb_adder_4bit.sv | 126 ++++++++++++
 2 files changed

// File: rtl/adder_4bit.sv
// Registered WIDTH-bit unsigned adder built from an explicit ripple-carry chain.
// Produces the wrapped sum, carry-out and two's-complement overflow one cycle after a valid operation.

module adder_4bit_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid
);
    // c[i] is the carry into bit i; there is no carry-in
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        adder_4bit_fa u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    logic [WIDTH-1:0] q_d, q_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             out_valid_d, out_valid_q;

    // Idle cycles hold the last result so a and b are don't-care when in_valid=0
    always_comb begin
        q_d         = q_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            q_d         = s;
            cout_d      = c[WIDTH];
            ovf_d       = c[WIDTH-1] ^ c[WIDTH];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            q_q         <= q_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign q         = q_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: directed test-plan cases, exhaustive pairs and
// randomized traffic against an arithmetic reference model.

module tb_adder_4bit;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic [W-1:0] q;
    logic         cout, ovf, out_valid;

    int errs   = 0;
    int checks = 0;

    // reference state: what the outputs should read after the most recent edge
    int m_q    = 0;
    int m_cout = 0;
    int m_ovf  = 0;
    int m_v    = 0;

    adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .q         (q),
        .cout      (cout),
        .ovf       (ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int x);
        return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    endfunction

    function automatic int ref_ovf(input int x, input int y);
        int s;
        s = to_signed(x) + to_signed(y);
        return (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
    endfunction

    // apply one cycle of inputs, advance the model, then compare all outputs
    task automatic step(input logic r, input logic v, input int x, input int y, input string tag);
        int sum;
        rst      = r;
        in_valid = v;
        a        = x[W-1:0];
        b        = y[W-1:0];
        @(posedge clk);
        #1;
        if (r) begin
            m_q = 0; m_cout = 0; m_ovf = 0; m_v = 0;
        end else if (v) begin
            sum    = x + y;
            m_q    = sum % (1 << W);
            m_cout = sum / (1 << W);
            m_ovf  = ref_ovf(x, y);
            m_v    = 1;
        end else begin
            m_v = 0;
        end
        chk({tag, ".q"},    int'(q),         m_q);
        chk({tag, ".cout"}, int'(cout),      m_cout);
        chk({tag, ".ovf"},  int'(ovf),       m_ovf);
        chk({tag, ".vld"},  int'(out_valid), m_v);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;

        step(1, 1, 15, 15, "rst0");
        step(1, 1, 15, 15, "rst1");
        chk("rst_q_const", int'(q), 0);

        step(0, 1, 0, 0, "zero");
        chk("zero_vld_const", int'(out_valid), 1);
        step(0, 1, 5, 10, "nocarry");
        chk("nocarry_q_const", int'(q), 'hf);

        step(0, 1, 7, 10, "wrap0");
        chk("wrap0_const", int'({cout, q}), 'h11);
        step(0, 1, 1, 15, "wrap1");
        chk("wrap1_const", int'({cout, q}), 'h10);
        step(0, 1, 15, 15, "wrap2");
        chk("wrap2_const", int'({cout, ovf, q}), 'h2e);

        step(0, 1, 7, 1, "ovf0");
        chk("ovf0_const", int'({cout, ovf, q}), 'h18);
        step(0, 1, 8, 8, "ovf1");
        chk("ovf1_const", int'({cout, ovf, q}), 'h30);

        step(0, 1, 5, 10, "hold_acc");
        step(0, 0, 3, 3, "hold");
        chk("hold_q_const", int'(q), 'hf);
        chk("hold_vld_const", int'(out_valid), 0);
        step(1, 0, 3, 3, "hold_rst");
        chk("hold_rst_const", int'(q), 0);

        // mid-operation reset clears the just-accepted result
        step(0, 1, 9, 9, "mid_acc");
        step(1, 1, 4, 4, "mid_rst");

        for (int i = 0; i < 256; i++)
            step(0, 1, i / 16, i % 16, "exh");

        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 15), "rnd");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
